// File: rtl/seg_scan_outport.sv
// Multi-digit seven-segment output port: CPU-loaded hex digits with per-digit blanking,
// scanned onto one shared segment bus with one-hot digit enables.
module seg_scan_outport #(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 1000,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int AN_ACTIVE_LOW  = 1,
   parameter int AW             = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [3:0]            wr_data,
   input  logic                  wr_blank,
   output logic [6:0]            seg_out,
   output logic [NUM_DIGITS-1:0] an_out,
   output logic                  frame_start
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   typedef struct packed {
      logic       blank;
      logic [3:0] nib;
   } digit_t;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   digit_t                  digit_q [NUM_DIGITS];
   digit_t                  digit_d [NUM_DIGITS];
   logic                    run_q, run_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic                    wrap_q, wrap_d;
   logic [6:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    frame_q, frame_d;
   digit_t                  cur;
   logic [NUM_DIGITS-1:0]   an_hot;

   always_comb begin
      digit_d = digit_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (wr_en && (wr_addr == AW'(i))) begin
            digit_d[i] = '{blank: wr_blank, nib: wr_data};
         end
      end

      cur    = digit_q[0];
      an_hot = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            cur       = digit_q[i];
            an_hot[i] = 1'b1;
         end
      end

      // run_q holds the scan and outputs dark for one cycle after reset release
      run_d   = 1'b1;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      seg_d   = SEG_OFF;
      an_d    = AN_OFF;
      frame_d = 1'b0;
      if (run_q) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            wrap_d = (idx_q == IDX_LAST);
            idx_d  = wrap_d ? '0 : idx_q + 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         seg_d   = cur.blank ? SEG_OFF : (hex7(cur.nib) ^ SEG_OFF);
         an_d    = an_hot ^ AN_OFF;
         // delayed one stage so the pulse lines up with digit 0 on an_out
         frame_d = wrap_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_q[i] <= '{blank: 1'b1, nib: 4'h0};
         end
         run_q   <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
         seg_q   <= SEG_OFF;
         an_q    <= AN_OFF;
         frame_q <= 1'b0;
      end else begin
         digit_q <= digit_d;
         run_q   <= run_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wrap_q  <= wrap_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         frame_q <= frame_d;
      end
   end

   assign seg_out     = seg_q;
   assign an_out      = an_q;
   assign frame_start = frame_q;

endmodule

// File: tb/tb_seg_scan_outport.sv
// Bench for seg_scan_outport: three parameter sets share one write bus and reset,
// each checked every cycle against a position-based display model.
module tb_seg_scan_outport;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = '0;
   logic [3:0] wr_data = '0;
   logic       wr_blank = 1'b0;

   logic [6:0] seg_a, seg_b, seg_c;
   logic [3:0] an_a, an_c;
   logic [0:0] an_b;
   logic       fr_a, fr_b, fr_c;

   always #5 clk = ~clk;

   seg_scan_outport #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1), .AW(4)) u_a (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_blank(wr_blank), .seg_out(seg_a), .an_out(an_a), .frame_start(fr_a));
   seg_scan_outport #(.NUM_DIGITS(1), .SCAN_DIV(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1), .AW(4)) u_b (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_blank(wr_blank), .seg_out(seg_b), .an_out(an_b), .frame_start(fr_b));
   seg_scan_outport #(.NUM_DIGITS(4), .SCAN_DIV(2), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(0), .AW(4)) u_c (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_blank(wr_blank), .seg_out(seg_c), .an_out(an_c), .frame_start(fr_c));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: after release, output at edge k shows position p=k-2 of the scan
   logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   int nd_p  [3] = '{4, 1, 4};
   int sd_p  [3] = '{4, 1, 2};
   int sal_p [3] = '{0, 0, 1};
   int aal_p [3] = '{1, 1, 0};

   logic [3:0] m_nib [3][16];
   logic       m_blk [3][16];
   int         m_seg [3];
   int         m_an  [3];
   int         m_fr  [3];
   int         k = 0;
   bit         mvalid = 0;

   initial begin
      int p, ix, s, a, msk;
      forever begin
         @(posedge clk);
         if (rst) begin
            mvalid = 1;
            k = 0;
            for (int d = 0; d < 3; d++) begin
               for (int i = 0; i < 16; i++) begin
                  m_nib[d][i] = 4'h0;
                  m_blk[d][i] = 1'b1;
               end
               msk = (1 << nd_p[d]) - 1;
               m_seg[d] = sal_p[d] != 0 ? 'h7F : 0;
               m_an[d]  = aal_p[d] != 0 ? msk : 0;
               m_fr[d]  = 0;
            end
         end else if (mvalid) begin
            k++;
            for (int d = 0; d < 3; d++) begin
               msk = (1 << nd_p[d]) - 1;
               if (k >= 2) begin
                  p  = k - 2;
                  ix = (p / sd_p[d]) % nd_p[d];
                  s  = m_blk[d][ix] ? 0 : int'(dec[m_nib[d][ix]]);
                  m_seg[d] = sal_p[d] != 0 ? (s ^ 'h7F) : s;
                  a  = 1 << ix;
                  m_an[d]  = aal_p[d] != 0 ? (a ^ msk) : a;
                  m_fr[d]  = (p > 0 && (p % (sd_p[d] * nd_p[d])) == 0) ? 1 : 0;
               end else begin
                  m_seg[d] = sal_p[d] != 0 ? 'h7F : 0;
                  m_an[d]  = aal_p[d] != 0 ? msk : 0;
                  m_fr[d]  = 0;
               end
               if (wr_en && int'(wr_addr) < nd_p[d]) begin
                  m_nib[d][wr_addr] = wr_data;
                  m_blk[d][wr_addr] = wr_blank;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (mvalid) begin
            chk("model seg_a", int'(seg_a), m_seg[0]);
            chk("model an_a", int'(an_a), m_an[0]);
            chk("model frame_a", int'(fr_a), m_fr[0]);
            chk("model seg_b", int'(seg_b), m_seg[1]);
            chk("model an_b", int'(an_b), m_an[1]);
            chk("model frame_b", int'(fr_b), m_fr[1]);
            chk("model seg_c", int'(seg_c), m_seg[2]);
            chk("model an_c", int'(an_c), m_an[2]);
            chk("model frame_c", int'(fr_c), m_fr[2]);
         end
      end
   end

   function automatic int get_an(input int d);
      if (d == 0) return int'(an_a);
      if (d == 1) return int'(an_b);
      return int'(an_c);
   endfunction

   task automatic wait_an(input int d, input int val, input int lim, input string nm);
      bit hit = 0;
      for (int i = 0; i < lim && !hit; i++) begin
         @(negedge clk);
         if (get_an(d) == val) hit = 1;
      end
      if (!hit) chk({nm, " timeout"}, get_an(d), val);
   endtask

   typedef struct {
      logic [3:0] addr;
      logic [3:0] data;
      logic       blank;
      logic [6:0] seg;
   } vec_t;

   vec_t tv [18];
   logic [6:0] load_seg [4];

   initial begin
      int nfr;
      bit hit;
      tv[0]  = '{4'd0, 4'h0, 1'b0, 7'h3F};
      tv[1]  = '{4'd0, 4'h1, 1'b0, 7'h06};
      tv[2]  = '{4'd0, 4'h2, 1'b0, 7'h5B};
      tv[3]  = '{4'd0, 4'h3, 1'b0, 7'h4F};
      tv[4]  = '{4'd0, 4'h4, 1'b0, 7'h66};
      tv[5]  = '{4'd0, 4'h5, 1'b0, 7'h6D};
      tv[6]  = '{4'd0, 4'h6, 1'b0, 7'h7D};
      tv[7]  = '{4'd0, 4'h7, 1'b0, 7'h07};
      tv[8]  = '{4'd0, 4'h8, 1'b0, 7'h7F};
      tv[9]  = '{4'd0, 4'h9, 1'b0, 7'h6F};
      tv[10] = '{4'd0, 4'hA, 1'b0, 7'h77};
      tv[11] = '{4'd0, 4'hB, 1'b0, 7'h7C};
      tv[12] = '{4'd0, 4'hC, 1'b0, 7'h39};
      tv[13] = '{4'd0, 4'hD, 1'b0, 7'h5E};
      tv[14] = '{4'd0, 4'hE, 1'b0, 7'h79};
      tv[15] = '{4'd0, 4'hF, 1'b0, 7'h71};
      tv[16] = '{4'd0, 4'h8, 1'b1, 7'h00};
      tv[17] = '{4'd5, 4'h9, 1'b0, 7'h00};
      load_seg = '{7'h06, 7'h5B, 7'h4F, 7'h66};

      // reset state and blank scan
      repeat (3) @(negedge clk);
      chk("reset seg_a", int'(seg_a), 'h00);
      chk("reset an_a", int'(an_a), 'hF);
      chk("reset frame_a", int'(fr_a), 0);
      chk("reset an_c", int'(an_c), 'h0);
      chk("reset seg_c", int'(seg_c), 'h7F);
      rst = 1'b0;
      @(negedge clk);
      chk("first edge an_a dark", int'(an_a), 'hF);
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         chk("blank scan an_a", int'(an_a), (~(1 << (j / 4))) & 'hF);
         chk("blank scan seg_a", int'(seg_a), 'h00);
      end

      // load 1..4 and follow one frame
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_addr = 4'(i); wr_data = 4'(i + 1); wr_blank = 1'b0;
         @(negedge clk);
      end
      wr_en = 1'b0;
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         if (fr_a) hit = 1;
      end
      chk("frame_a seen", int'(hit), 1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) repeat (4) @(negedge clk);
         chk("load seg_a", int'(seg_a), int'(load_seg[i]));
         chk("load an_a", int'(an_a), (~(1 << i)) & 'hF);
      end
      nfr = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (fr_a) nfr++;
      end
      chk("frame_a per 32 cycles", nfr, 2);

      // decode sweep on the single-digit instance
      foreach (tv[i]) begin
         wr_en = 1'b1; wr_addr = tv[i].addr; wr_data = tv[i].data; wr_blank = tv[i].blank;
         @(negedge clk);
         wr_en = 1'b0;
         @(negedge clk);
         chk($sformatf("decode row %0d seg_b", i), int'(seg_b), int'(tv[i].seg));
      end

      // blanked digit keeps its enable
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'h8; wr_blank = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      wait_an(0, 'hB, 24, "an_a digit2");
      chk("blank digit2 seg_a", int'(seg_a), 'h00);
      chk("blank digit2 an_a", int'(an_a), 'hB);

      // dense writes, many landing on the displayed digit as the index moves
      for (int i = 0; i < 48; i++) begin
         wr_en = 1'b1; wr_addr = 4'($urandom_range(0, 3));
         wr_data = 4'($urandom); wr_blank = ($urandom_range(0, 5) == 0);
         @(negedge clk);
      end
      wr_en = 1'b0;

      // polarity and reset mid-frame on the inverted instance
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'h0; wr_blank = 1'b0;
      @(negedge clk);
      wr_en = 1'b0;
      wait_an(2, 'h1, 20, "an_c digit0");
      chk("polarity seg_c", int'(seg_c), 'h40);
      wait_an(2, 'h4, 20, "an_c digit2");
      rst = 1'b1;
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'h5; wr_blank = 1'b0;
      @(negedge clk);
      wr_en = 1'b0;
      chk("mid reset an_c", int'(an_c), 'h0);
      chk("mid reset seg_c", int'(seg_c), 'h7F);
      chk("mid reset frame_c", int'(fr_c), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("restart an_c dark", int'(an_c), 'h0);
      @(negedge clk);
      chk("restart an_c digit0", int'(an_c), 'h1);
      chk("restart seg_c blank", int'(seg_c), 'h7F);

      // randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         wr_en    = ($urandom_range(0, 1) == 1);
         wr_addr  = 4'($urandom_range(0, 7));
         wr_data  = 4'($urandom);
         wr_blank = ($urandom_range(0, 3) == 0);
         rst      = ($urandom_range(0, 99) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      wr_en = 1'b0;
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_outport.md
Name: seg_scan_outport

Overview:
Parametrised successor to the two-digit registered seven-segment output port. Holds NUM_DIGITS loadable hex digits, each with its own blank flag. Drives one shared 7-bit segment bus plus one-hot digit enables by time-multiplexed scanning, so a multi-digit display can be driven from one segment bus. Sits at the processor output boundary; the CPU writes digits through an addressed write port.

Parameters:
NUM_DIGITS, 4, number of digit registers/enables; legal 1..16
SCAN_DIV, 1000, clk cycles each digit is displayed; legal >= 1
SEG_ACTIVE_LOW, 0, 1 inverts seg_out (common-anode panels)
AN_ACTIVE_LOW, 1, 1 inverts an_out
AW, 4, wr_addr width; must satisfy 2^AW >= NUM_DIGITS

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
wr_en  input  1  write strobe for one digit register
wr_addr  input  AW  digit index to write; values >= NUM_DIGITS are ignored
wr_data  input  4  hex nibble to store
wr_blank  input  1  blank flag stored with the nibble; 1 = digit dark
seg_out  output  7  registered segments {g,f,e,d,c,b,a}, bit0 = a
an_out  output  NUM_DIGITS  registered one-hot digit enable, bit i = digit i
frame_start  output  1  one-cycle pulse when scan returns to digit 0

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst); it takes effect only on a clk edge.
- Reset values: all nibbles 0, all blank flags 1, scan counter 0, scan index 0, seg_out all segments off, an_out all enables off, frame_start 0. Polarity parameters apply to every "off" value.
- Write port:
  - On a rising edge with wr_en=1 and wr_addr < NUM_DIGITS, digit[wr_addr] <= {wr_blank, wr_data}.
  - An out-of-range address does nothing.
  - No handshake; every accepted write commits in the same edge.
- Scan counter:
  - Counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and the index advances.
  - Index runs 0..NUM_DIGITS-1, then wraps to 0.
  - With SCAN_DIV=1 the index advances every cycle. With NUM_DIGITS=1 the index stays 0.
- frame_start: asserted for exactly the one cycle after the index goes from NUM_DIGITS-1 to 0. Never asserted in the first frame after reset.
- Output stage, one-cycle registered latency from index and digit state:
  - an_out has only bit[index] active.
  - seg_out = decode(digit[index].nibble), or all off if digit[index].blank=1.
  - The enable bit for a blanked digit remains driven.
- Decode table (active-high, hex):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - SEG_ACTIVE_LOW inverts the final value.
- Write to the digit being displayed: the edge that commits the write updates the register. seg_out shows the new value on the following edge, with no tearing.
- Write and index advance in the same edge: both take effect. The next output reflects the new index, with the written value if the addresses match.
- rst asserted mid-scan or mid-write: reset wins. The write is discarded and the scan restarts at index 0, count 0.
- After reset release, the first active enable (digit 0) appears on the second edge.
- Only one enable is ever active at a time; all enables are off only during reset.

Test Plan:
- Reset check, NUM_DIGITS=4, SCAN_DIV=4, defaults: assert rst 3 cycles -> seg_out=7'h00, an_out=4'b1111, frame_start=0. Release rst -> an_out cycles 1110,1101,1011,0111 with 4 cycles each; seg_out=00 throughout because all digits are blank.
- Load and scan: write addr0..3 with data 1,2,3,4 and blank=0 -> seg_out=06 with an bit0 active, then 5B, 4F, 66 on the following digits. frame_start pulses once per 16 cycles, in the cycle when digit 0 reappears.
- Full decode sweep, NUM_DIGITS=1, SCAN_DIV=1: write each nibble 0..F -> seg_out matches the table one cycle after each commit (3F, 06, ... 71).
- Blank and out-of-range: write addr2 with data=8 and blank=1 -> seg_out=00 while an bit2 is active. Write addr 5 with data=9 -> no digit changes.
- Collision: write the displayed digit in the same edge the index advances, with SCAN_DIV=2 -> no glitch cycle, and each output matches the reference model every cycle.
- Polarity and reset mid-frame: SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=0, digit0=0 -> seg_out=7'h40. Assert rst during index 2 -> next edge gives an_out=0 and seg_out=7F; after release the scan restarts at digit 0.
